axi4_lite_read_slave_pipelined: RTL and testbench

//  AXI4-Lite read-channel slave accepting up to MAX_OUTSTANDING reads; AR channel decoupled from R channel.

---
 rtl/axi4_lite_read_slave_pipelined_if.sv | 24 ++
 rtl/axi4_lite_read_slave_pipelined.sv | 251 +++++++++++++++++++++++++
 tb/tb_axi4_lite_read_slave_pipelined.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_read_slave_pipelined_if.sv
// AXI4-Lite read-channel bundle (AR + R) shared by the read slave and its master.
// Signal names follow the AXI port names of the slave; modports give each side's direction.
interface axi4_lite_read_slave_pipelined_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR;
  logic                  S_AXI_ARVALID;
  logic                  S_AXI_ARREADY;
  logic [DATA_WIDTH-1:0] S_AXI_RDATA;
  logic [1:0]            S_AXI_RRESP;
  logic                  S_AXI_RVALID;
  logic                  S_AXI_RREADY;

  modport slave (
    input  S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport master (
    output S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/axi4_lite_read_slave_pipelined.sv
// Pipelined AXI4-Lite read slave: ordered cmd FIFO -> single-in-flight backend FSM -> resp FIFO -> R.
// Optional backend timeout enabled by defining AXIL_RD_TIMEOUT_EN.
module axi4_lite_read_slave_pipelined #(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    MAX_OUTSTANDING = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0,
  parameter logic [ADDR_WIDTH-1:0] SIZE_BYTES      = ADDR_WIDTH'('h1000),
  parameter int                    TIMEOUT_CYCLES  = 256
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  axi4_lite_read_slave_pipelined_if.slave       s_axi,
  output logic                                  mem_req_valid,
  input  logic                                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0]                 mem_addr,
  input  logic                                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]                 mem_rdata,
  input  logic                                  mem_rsp_err
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int ADDR_LSB = $clog2(DATA_WIDTH / 8);
  localparam int PTR_W    = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W    = $clog2(MAX_OUTSTANDING + 1);
  localparam int CMD_W    = ADDR_WIDTH + 2;
  localparam int RSP_W    = DATA_WIDTH + 2;
  localparam logic [ADDR_WIDTH-1:0] WIN_MASK = ~(SIZE_BYTES - ADDR_WIDTH'(1));

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_chk_dw
    $error("DATA_WIDTH must be 32 or 64");
  end
  if (MAX_OUTSTANDING < 2 || (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0) begin : g_chk_mo
    $error("MAX_OUTSTANDING must be a power of 2 and >= 2");
  end
  if ((SIZE_BYTES & (SIZE_BYTES - ADDR_WIDTH'(1))) != '0 || (BASE_ADDR & ~WIN_MASK) != '0) begin : g_chk_win
    $error("SIZE_BYTES must be a power of 2 with BASE_ADDR aligned to it");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_chk_to
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  // ---------------- AR channel and outstanding bound ----------------
  logic             arready_q, arready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ar_hs, r_hs;
  logic [1:0]       ar_chk;
  logic             rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]       rresp_q, rresp_d;

  assign ar_hs = s_axi.S_AXI_ARVALID && arready_q;
  assign r_hs  = rvalid_q && s_axi.S_AXI_RREADY;

  // Decode error wins over misalignment.
  always_comb begin
    ar_chk = RESP_OKAY;
    if ((s_axi.S_AXI_ARADDR & WIN_MASK) != BASE_ADDR) begin
      ar_chk = RESP_DECERR;
    end else if (s_axi.S_AXI_ARADDR[ADDR_LSB-1:0] != '0) begin
      ar_chk = RESP_SLVERR;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (ar_hs && !r_hs) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!ar_hs && r_hs) begin
      cnt_d = cnt_q - 1'b1;
    end
    arready_d = (cnt_d < CNT_W'(MAX_OUTSTANDING));
  end

  // ---------------- Command FIFO ----------------
  logic [CMD_W-1:0]      cf_mem [MAX_OUTSTANDING];
  logic [PTR_W:0]        cf_wr_q, cf_rd_q;
  logic                  cf_empty, cf_push, cf_pop, bypass;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [1:0]            head_chk;

  assign cf_empty              = (cf_wr_q == cf_rd_q);
  assign {head_addr, head_chk} = cf_mem[cf_rd_q[PTR_W-1:0]];
  // An OK read arriving at an idle, empty pipe skips the FIFO so the backend sees it next cycle.
  assign cf_push               = ar_hs && !bypass;

  always_ff @(posedge clk) begin
    if (cf_push) begin
      cf_mem[cf_wr_q[PTR_W-1:0]] <= {s_axi.S_AXI_ARADDR, ar_chk};
    end
  end

  // ---------------- Issue FSM ----------------
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  rsp_push;
  logic [DATA_WIDTH-1:0] rsp_push_data;
  logic [1:0]            rsp_push_resp;

`ifdef AXIL_RD_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] timer_q, timer_d;
`endif

  always_comb begin
    state_d       = state_q;
    mem_addr_d    = mem_addr_q;
    cf_pop        = 1'b0;
    bypass        = 1'b0;
    rsp_push      = 1'b0;
    rsp_push_data = '0;
    rsp_push_resp = RESP_OKAY;
`ifdef AXIL_RD_TIMEOUT_EN
    timer_d       = timer_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!cf_empty) begin
          cf_pop = 1'b1;
          if (head_chk != RESP_OKAY) begin
            rsp_push      = 1'b1;
            rsp_push_resp = head_chk;
          end else begin
            mem_addr_d = head_addr;
            state_d    = S_REQ;
          end
        end else if (ar_hs && ar_chk == RESP_OKAY) begin
          bypass     = 1'b1;
          mem_addr_d = s_axi.S_AXI_ARADDR;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
`ifdef AXIL_RD_TIMEOUT_EN
        timer_d = '0;
`endif
        if (mem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          rsp_push      = 1'b1;
          rsp_push_data = mem_rdata;
          rsp_push_resp = mem_rsp_err ? RESP_SLVERR : RESP_OKAY;
          state_d       = S_IDLE;
`ifdef AXIL_RD_TIMEOUT_EN
        end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_push      = 1'b1;
          rsp_push_resp = RESP_SLVERR;
          state_d       = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_req_valid = (state_q == S_REQ);
  assign mem_addr      = mem_addr_q;

  // ---------------- Response FIFO + R output register ----------------
  logic [RSP_W-1:0] rf_mem [MAX_OUTSTANDING];
  logic [PTR_W:0]   rf_wr_q, rf_rd_q;
  logic             rf_empty, rf_push, rf_pop, out_load;
  logic [RSP_W-1:0] rf_head;

  assign rf_empty = (rf_wr_q == rf_rd_q);
  assign rf_head  = rf_mem[rf_rd_q[PTR_W-1:0]];
  assign out_load = !rvalid_q || s_axi.S_AXI_RREADY;

  // The output register is the real head; the FIFO only holds what queues behind it.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rf_pop   = 1'b0;
    rf_push  = rsp_push;
    if (out_load) begin
      if (!rf_empty) begin
        rvalid_d           = 1'b1;
        {rdata_d, rresp_d} = rf_head;
        rf_pop             = 1'b1;
      end else if (rsp_push) begin
        rvalid_d = 1'b1;
        rdata_d  = rsp_push_data;
        rresp_d  = rsp_push_resp;
        rf_push  = 1'b0;
      end else begin
        rvalid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rf_push) begin
      rf_mem[rf_wr_q[PTR_W-1:0]] <= {rsp_push_data, rsp_push_resp};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arready_q  <= 1'b0;
      cnt_q      <= '0;
      cf_wr_q    <= '0;
      cf_rd_q    <= '0;
      rf_wr_q    <= '0;
      rf_rd_q    <= '0;
      state_q    <= S_IDLE;
      mem_addr_q <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      arready_q  <= arready_d;
      cnt_q      <= cnt_d;
      if (cf_push) cf_wr_q <= cf_wr_q + 1'b1;
      if (cf_pop)  cf_rd_q <= cf_rd_q + 1'b1;
      if (rf_push) rf_wr_q <= rf_wr_q + 1'b1;
      if (rf_pop)  rf_rd_q <= rf_rd_q + 1'b1;
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

`ifdef AXIL_RD_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`endif

  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;

endmodule

// File: tb/tb_axi4_lite_read_slave_pipelined.sv
// Scoreboard bench for axi4_lite_read_slave_pipelined: expected beats queued at AR handshake,
// compared at R handshake; a small backend model answers one cycle after each request.
module tb_axi4_lite_read_slave_pipelined;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi4_lite_read_slave_pipelined_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_rsp_valid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_rsp_err = 1'b0;

  axi4_lite_read_slave_pipelined #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(4),
    .BASE_ADDR(32'h0), .SIZE_BYTES(32'h1000), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_axi(bus.slave),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .mem_rsp_err(mem_rsp_err)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- backend model ----------------
  bit          be_silent = 1'b0;
  logic [AW-1:0] be_err_addr = 32'hFFFF_FFFF;
  int          force_at = -1;
  bit          hs_next = 1'b0;
  logic [AW-1:0] hs_addr = '0;
  logic [AW-1:0] be_addr = '0;
  int          be_cnt = 0;
  int          req_count = 0;
  bit          bad_req = 1'b0;

  function automatic logic [DW-1:0] be_data(input logic [AW-1:0] a);
    if (a == 32'h10) return 32'hDEAD_BEEF;
    return {16'hC0DE ^ a[15:0], a[15:0]};
  endfunction

  always @(negedge clk) begin
    hs_next = (mem_req_valid === 1'b1) && (mem_req_ready === 1'b1) && rst_n;
    hs_addr = mem_addr;
    if (hs_next) begin
      req_count++;
      if (mem_addr >= 32'h1000 || mem_addr[1:0] != 2'b00) bad_req = 1'b1;
    end
  end

  always @(posedge clk) begin
    #1;
    mem_rsp_valid = 1'b0;
    mem_rsp_err   = 1'b0;
    mem_rdata     = 32'hBAD0_BAD0;
    if (hs_next) begin
      be_cnt  = 1;
      be_addr = hs_addr;
    end
    if (be_cnt > 0) begin
      be_cnt--;
      if (be_cnt == 0 && !be_silent) begin
        mem_rsp_valid = 1'b1;
        mem_rdata     = be_data(be_addr);
        mem_rsp_err   = (be_addr == be_err_addr);
      end
    end
    if (cyc == force_at) begin
      mem_rsp_valid = 1'b1;
      mem_rdata     = 32'h1A7E_1A7E;
    end
  end

  // ---------------- scoreboard / R channel service ----------------
  logic [DW+1:0] exp_q[$];
  bit            hold_prev = 1'b0;
  logic [DW-1:0] hold_data = '0;
  logic [1:0]    hold_resp = '0;
  int            r_count = 0;
  int            hs_cyc = 0;

  function automatic logic [DW+1:0] expect_of(input logic [AW-1:0] a);
    if (a >= 32'h1000) return {32'h0, 2'b11};
    if (a[1:0] != 2'b00) return {32'h0, 2'b10};
    if (be_silent) return {32'h0, 2'b10};
    return {be_data(a), (a == be_err_addr) ? 2'b10 : 2'b00};
  endfunction

  // Evaluates the R channel as it stands before the coming posedge, then advances one cycle.
  task automatic tick();
    logic [DW+1:0] e;
    if (hold_prev) begin
      checks++;
      if (bus.S_AXI_RVALID !== 1'b1 || bus.S_AXI_RDATA !== hold_data || bus.S_AXI_RRESP !== hold_resp) begin
        errors++;
        $display("FAIL r_stable: got valid=%b data=%h resp=%b, required valid=1 data=%h resp=%b",
                 bus.S_AXI_RVALID, bus.S_AXI_RDATA, bus.S_AXI_RRESP, hold_data, hold_resp);
      end
    end
    if (bus.S_AXI_RVALID === 1'b1 && bus.S_AXI_RREADY === 1'b1) begin
      checks++;
      r_count++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL r_unexpected: got data=%h resp=%b, required no beat", bus.S_AXI_RDATA, bus.S_AXI_RRESP);
      end else begin
        e = exp_q.pop_front();
        if ({bus.S_AXI_RDATA, bus.S_AXI_RRESP} !== e) begin
          errors++;
          $display("FAIL r_beat: got data=%h resp=%b, required data=%h resp=%b",
                   bus.S_AXI_RDATA, bus.S_AXI_RRESP, e[DW+1:2], e[1:0]);
        end else begin
          $display("R beat data=%h resp=%b ok (cycle %0d)", bus.S_AXI_RDATA, bus.S_AXI_RRESP, cyc);
        end
      end
    end
    hold_prev = (bus.S_AXI_RVALID === 1'b1) && (bus.S_AXI_RREADY !== 1'b1);
    hold_data = bus.S_AXI_RDATA;
    hold_resp = bus.S_AXI_RRESP;
    @(negedge clk);
  endtask

  task automatic ar_send(input logic [AW-1:0] a);
    int n = 0;
    bus.S_AXI_ARADDR  = a;
    bus.S_AXI_ARVALID = 1'b1;
    while (bus.S_AXI_ARREADY !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (bus.S_AXI_ARREADY !== 1'b1) begin
      errors++;
      $display("FAIL ar_accept: addr=%h got arready=%b, required 1 within 100 cycles", a, bus.S_AXI_ARREADY);
      bus.S_AXI_ARVALID = 1'b0;
      return;
    end
    hs_cyc = cyc;
    exp_q.push_back(expect_of(a));
    $display("AR addr=%h accepted (cycle %0d)", a, cyc);
    tick();
    bus.S_AXI_ARVALID = 1'b0;
  endtask

  task automatic wait_rvalid();
    int n = 0;
    while (bus.S_AXI_RVALID !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d beats outstanding, required 0", exp_q.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (bus.S_AXI_ARREADY !== 1'b0 || bus.S_AXI_RVALID !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: got arready=%b rvalid=%b, required 0 0", bus.S_AXI_ARREADY, bus.S_AXI_RVALID);
    end
    checks++;
    if (bus.S_AXI_RDATA !== 32'h0 || bus.S_AXI_RRESP !== 2'b00) begin
      errors++;
      $display("FAIL reset_rdata: got data=%h resp=%b, required 0 00", bus.S_AXI_RDATA, bus.S_AXI_RRESP);
    end
    checks++;
    if (mem_req_valid !== 1'b0 || mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_mem: got req_valid=%b addr=%h, required 0 0", mem_req_valid, mem_addr);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.S_AXI_ARREADY !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_arready: got %b, required 1", bus.S_AXI_ARREADY);
    end
    $display("reset test done");
  endtask

  task automatic test_latency();
    int c0;
    int rc0;
    bus.S_AXI_RREADY = 1'b1;
    rc0 = req_count;
    ar_send(32'h10);
    c0 = hs_cyc;
    checks++;
    if (mem_req_valid !== 1'b1 || mem_addr !== 32'h10 || cyc != c0 + 1) begin
      errors++;
      $display("FAIL lat_req: got req_valid=%b addr=%h at c%0d, required 1 00000010 at c1",
               mem_req_valid, mem_addr, cyc - c0);
    end
    wait_rvalid();
    checks++;
    if (cyc != c0 + 3) begin
      errors++;
      $display("FAIL lat_rvalid: got RVALID at c%0d, required c3", cyc - c0);
    end
    tick();
    ar_send(32'h6);
    c0 = hs_cyc;
    wait_rvalid();
    checks++;
    if (cyc != c0 + 2) begin
      errors++;
      $display("FAIL lat_err_rvalid: got RVALID at c%0d, required c2", cyc - c0);
    end
    wait_drain();
    checks++;
    if (req_count != rc0 + 1) begin
      errors++;
      $display("FAIL lat_req_count: got %0d backend reqs, required %0d", req_count - rc0, 1);
    end
  endtask

  task automatic test_slverr_backend();
    bus.S_AXI_RREADY = 1'b1;
    be_err_addr = 32'h8;
    ar_send(32'h8);
    wait_drain();
    be_err_addr = 32'hFFFF_FFFF;
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addrs [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    int r0;
    bus.S_AXI_RREADY = 1'b0;
    r0 = r_count;
    foreach (addrs[i]) ar_send(addrs[i]);
    bus.S_AXI_ARADDR  = 32'h10;
    bus.S_AXI_ARVALID = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus.S_AXI_ARREADY !== 1'b0) begin
        errors++;
        $display("FAIL b2b_full_arready: got %b at stall cycle %0d, required 0", bus.S_AXI_ARREADY, k);
      end
      tick();
    end
    wait_rvalid();
    bus.S_AXI_RREADY = 1'b1;
    tick();
    bus.S_AXI_RREADY = 1'b0;
    ar_send(32'h10);
    bus.S_AXI_RREADY = 1'b1;
    wait_drain();
    checks++;
    if (r_count - r0 != 5) begin
      errors++;
      $display("FAIL b2b_count: got %0d R beats, required 5", r_count - r0);
    end
  endtask

  task automatic test_decerr_order();
    int rc0;
    bus.S_AXI_RREADY = 1'b1;
    rc0 = req_count;
    ar_send(32'h20);
    ar_send(32'h2000);
    ar_send(32'h24);
    wait_drain();
    checks++;
    if (req_count - rc0 != 2 || bad_req) begin
      errors++;
      $display("FAIL decerr_no_req: got %0d backend reqs bad=%b, required 2 bad=0", req_count - rc0, bad_req);
    end
  endtask

  task automatic test_stall();
    logic [DW-1:0] d;
    logic [1:0]    r;
    bus.S_AXI_RREADY = 1'b0;
    ar_send(32'h30);
    wait_rvalid();
    d = bus.S_AXI_RDATA;
    r = bus.S_AXI_RRESP;
    repeat (5) tick();
    checks++;
    if (bus.S_AXI_RVALID !== 1'b1 || bus.S_AXI_RDATA !== d || bus.S_AXI_RRESP !== r) begin
      errors++;
      $display("FAIL stall_hold: got valid=%b data=%h resp=%b, required 1 %h %b",
               bus.S_AXI_RVALID, bus.S_AXI_RDATA, bus.S_AXI_RRESP, d, r);
    end
    bus.S_AXI_RREADY = 1'b1;
    wait_drain();
  endtask

  task automatic test_reset_in_wait();
    int n = 0;
    bus.S_AXI_RREADY = 1'b1;
    be_silent = 1'b1;
    ar_send(32'h40);
    while (mem_req_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.S_AXI_ARREADY !== 1'b0 || bus.S_AXI_RVALID !== 1'b0 || bus.S_AXI_RDATA !== 32'h0 ||
        bus.S_AXI_RRESP !== 2'b00 || mem_req_valid !== 1'b0 || mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_in_wait: got arready=%b rvalid=%b data=%h resp=%b req=%b addr=%h, required all 0",
               bus.S_AXI_ARREADY, bus.S_AXI_RVALID, bus.S_AXI_RDATA, bus.S_AXI_RRESP, mem_req_valid, mem_addr);
    end
    exp_q.delete();
    hold_prev = 1'b0;
    be_silent = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    // A cleared outstanding count must admit exactly four reads again.
    bus.S_AXI_RREADY = 1'b0;
    ar_send(32'h44);
    ar_send(32'h48);
    ar_send(32'h4C);
    ar_send(32'h50);
    checks++;
    if (bus.S_AXI_ARREADY !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_full: got arready=%b after 4 reads, required 0", bus.S_AXI_ARREADY);
    end
    bus.S_AXI_RREADY = 1'b1;
    wait_drain();
  endtask

`ifdef AXIL_RD_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    int wc;
    bus.S_AXI_RREADY = 1'b1;
    be_silent = 1'b1;
    ar_send(32'h60);
    while (mem_req_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    wc = cyc + 1;
    wait_rvalid();
    checks++;
    if (cyc != wc + 8) begin
      errors++;
      $display("FAIL timeout_cycle: got RVALID %0d cycles after WAIT, required 8", cyc - wc);
    end
    wait_drain();
    be_silent = 1'b0;
    force_at = cyc + 1;
    repeat (6) tick();
    checks++;
    if (r_count < 0 || bus.S_AXI_RVALID !== 1'b0) begin
      errors++;
      $display("FAIL timeout_late_rsp: got rvalid=%b, required 0", bus.S_AXI_RVALID);
    end
  endtask
`endif

  initial begin
    bus.S_AXI_ARADDR  = '0;
    bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY  = 1'b0;
    mem_req_ready     = 1'b1;
    test_reset();
    test_latency();
    test_slverr_backend();
    test_back_to_back();
    test_decerr_order();
    test_stall();
    test_reset_in_wait();
`ifdef AXIL_RD_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by 500000 ns, required finish");
    $fatal(1, "watchdog expired");
  end
endmodule
